// File: rtl/alu_128_bit.sv
// alu_128_bit: registered integer ALU for the execute stage.
// Each rising edge registers the result and the carry, zero, overflow and sign
// flags for one operation. A new operation is accepted every cycle.
// The registered carry is also the borrow-in for subtract-with-borrow.
// Optional build macro: ALU_ROL_EN enables rotate-left on logic opsel 110.
// Without it, that opcode is reserved.
module alu_128_bit #(
  parameter int DWIDTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              z_flag,
  output logic              o_flag,
  output logic              s_flag
);

  localparam int SW = $clog2(DWIDTH);

  // Opcode map: {mode, opsel}
  localparam logic [3:0] OP_ADD    = 4'b0_000;
  localparam logic [3:0] OP_SUBWB  = 4'b0_001;
  localparam logic [3:0] OP_MOV    = 4'b0_010;
  localparam logic [3:0] OP_SUB    = 4'b0_011;
  localparam logic [3:0] OP_INC    = 4'b0_100;
  localparam logic [3:0] OP_DEC    = 4'b0_101;
  localparam logic [3:0] OP_ADDINC = 4'b0_110;
  localparam logic [3:0] OP_AND    = 4'b1_000;
  localparam logic [3:0] OP_OR     = 4'b1_001;
  localparam logic [3:0] OP_XOR    = 4'b1_010;
  localparam logic [3:0] OP_NOT    = 4'b1_011;
  localparam logic [3:0] OP_MOVE   = 4'b1_100;
  localparam logic [3:0] OP_SHL    = 4'b1_101;
`ifdef ALU_ROL_EN
  localparam logic [3:0] OP_ROL    = 4'b1_110;
`endif

  // Constant one at the extended (carry-inclusive) width
  localparam logic [DWIDTH:0] ONE_X = {{DWIDTH{1'b0}}, 1'b1};

  // Output registers and their next-state values
  logic [DWIDTH-1:0] result_q, result_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              o_q, o_d;
  logic              s_q, s_d;

  // Operands widened by one bit, so bit DWIDTH is the carry/borrow
  logic [DWIDTH:0]   a_x;
  logic [DWIDTH:0]   b_x;
  logic [DWIDTH:0]   cin_x;
  logic [DWIDTH:0]   ext;
  logic [SW-1:0]     shamt;

  // Signed overflow for an addition, judged on the sign bits only.
  // The addends share a sign and the result sign differs from it.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow for a subtraction a - b, judged on the sign bits only.
  // The operand signs differ and the result sign differs from a.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

`ifdef ALU_ROL_EN
  // Rotate left by amt. An amount of zero returns the operand unchanged,
  // because the right shift by DWIDTH yields zero.
  function automatic logic [DWIDTH-1:0] rol_f(input logic [DWIDTH-1:0] v,
                                               input logic [SW-1:0]     amt);
    logic [SW:0] rsh;
    rsh = (SW+1)'(DWIDTH) - {1'b0, amt};
    return (v << amt) | (v >> rsh);
  endfunction
`endif

  assign a_x   = {1'b0, op1};
  assign b_x   = {1'b0, op2};
  assign cin_x = {{DWIDTH{1'b0}}, c_q};
  assign shamt = op2[SW-1:0];

  // Next-state logic: compute result and carry/overflow; zero/sign follow the result
  always_comb begin
    result_d = '0;
    c_d      = 1'b0;
    o_d      = 1'b0;
    ext      = '0;
    unique0 case ({mode, opsel})
      OP_ADD: begin
        ext      = a_x + b_x;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
        o_d      = add_ovf(op1[DWIDTH-1], op2[DWIDTH-1], ext[DWIDTH-1]);
      end
      OP_SUBWB: begin
        ext      = a_x - b_x - cin_x;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
        o_d      = sub_ovf(op1[DWIDTH-1], op2[DWIDTH-1], ext[DWIDTH-1]);
      end
      OP_MOV: begin
        result_d = op1;
      end
      OP_SUB: begin
        ext      = a_x - b_x;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
        o_d      = sub_ovf(op1[DWIDTH-1], op2[DWIDTH-1], ext[DWIDTH-1]);
      end
      OP_INC: begin
        ext      = a_x + ONE_X;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
        o_d      = add_ovf(op1[DWIDTH-1], 1'b0, ext[DWIDTH-1]);
      end
      OP_DEC: begin
        ext      = a_x - ONE_X;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
        o_d      = sub_ovf(op1[DWIDTH-1], 1'b0, ext[DWIDTH-1]);
      end
      OP_ADDINC: begin
        // The extra +1 acts as a carry-in. It does not count as an addend for overflow.
        ext      = a_x + b_x + ONE_X;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
        o_d      = add_ovf(op1[DWIDTH-1], op2[DWIDTH-1], ext[DWIDTH-1]);
      end
      OP_AND:  result_d = op1 & op2;
      OP_OR:   result_d = op1 | op2;
      OP_XOR:  result_d = op1 ^ op2;
      OP_NOT:  result_d = ~op1;
      OP_MOVE: result_d = op2;
      OP_SHL: begin
        // Bit DWIDTH of the widened shift is the last bit shifted out.
        // It stays 0 when the shift amount is zero.
        ext      = a_x << shamt;
        result_d = ext[DWIDTH-1:0];
        c_d      = ext[DWIDTH];
      end
`ifdef ALU_ROL_EN
      OP_ROL: begin
        result_d = rol_f(op1, shamt);
        c_d      = (shamt != '0) ? result_d[0] : 1'b0;
      end
`endif
      default: begin
        // Reserved or unknown select: result 0. The zero flag comes from the result below.
        result_d = '0;
      end
    endcase
    z_d = (result_d == '0);
    s_d = result_d[DWIDTH-1];
  end

  // Output register with synchronous reset that overrides any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      o_q      <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      o_q      <= o_d;
      s_q      <= s_d;
    end
  end

  assign result = result_q;
  assign c_flag = c_q;
  assign z_flag = z_q;
  assign o_flag = o_q;
  assign s_flag = s_q;

endmodule

// File: tb/tb_alu_128_bit.sv
// Scoreboard bench for alu_128_bit (DWIDTH=128).
// The stimulus process drives one operation per cycle and queues the
// hand-computed response. The monitor pops the queue and compares one cycle later.
module tb_alu_128_bit;

  localparam int DW = 128;

  typedef struct {
    logic [DW-1:0] res;
    logic          c, z, o, s;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] op1 = '0;
  logic [DW-1:0] op2 = '0;
  logic [2:0]    opsel = '0;
  logic          mode = 1'b0;
  logic [DW-1:0] result;
  logic          c_flag, z_flag, o_flag, s_flag;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [DW-1:0] ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO  = '0;
  localparam logic [DW-1:0] MSB   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAXP  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MSB1  = {1'b1, {(DW-2){1'b0}}, 1'b1};
  localparam logic [DW-1:0] TOP4  = {4'hF, {(DW-5){1'b0}}, 1'b1};
  localparam logic [DW-1:0] NOTF0 = {{(DW-16){1'b1}}, 16'h0F0F};

  alu_128_bit #(.DWIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .opsel  (opsel),
    .mode   (mode),
    .result (result),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .o_flag (o_flag),
    .s_flag (s_flag)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic m, input logic [2:0] sel,
                       input logic [DW-1:0] er, input logic ec, input logic ez,
                       input logic eo, input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; op1 = a; op2 = b; mode = m; opsel = sel;
    e.res = er; e.c = ec; e.z = ez; e.o = eo; e.s = es; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: every edge that captured a queued operation is checked just after the edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (result !== e.res || c_flag !== e.c || z_flag !== e.z ||
          o_flag !== e.o || s_flag !== e.s) begin
        errors++;
        $display("FAIL %s: got res=%h c=%b z=%b o=%b s=%b, expected res=%h c=%b z=%b o=%b s=%b",
                 e.name, result, c_flag, z_flag, o_flag, s_flag,
                 e.res, e.c, e.z, e.o, e.s);
      end
    end
  end

  initial begin
    // Reset held two edges with an add pending on the inputs
    issue(1, ONES, ONES, 0, 3'b000, ZERO, 0, 0, 0, 0, "reset0");
    issue(1, ONES, ONES, 0, 3'b000, ZERO, 0, 0, 0, 0, "reset1");
    issue(0, ONES, ONES, 0, 3'b000, {ONES[DW-1:1], 1'b0}, 1, 0, 0, 1, "add_after_reset");
    // Arithmetic
    issue(0, 128'hEE, 128'hEE, 0, 3'b110, 128'h1DD, 0, 0, 0, 0, "addinc");
    issue(0, MAXP, 128'h1, 0, 3'b000, MSB, 0, 0, 1, 1, "add_ovf");
    issue(0, ONES, ZERO, 0, 3'b100, ZERO, 1, 1, 0, 0, "inc_wrap");
    issue(0, ZERO, 128'h1, 0, 3'b011, ONES, 1, 0, 0, 1, "sub_borrow");
    issue(0, 128'h5, 128'h2, 0, 3'b001, 128'h2, 0, 0, 0, 0, "subwb_cin1");
    issue(0, 128'h5, 128'h2, 0, 3'b001, 128'h3, 0, 0, 0, 0, "subwb_cin0");
    issue(0, ZERO, ZERO, 0, 3'b101, ONES, 1, 0, 0, 1, "dec_zero");
    issue(0, ZERO, ZERO, 0, 3'b001, ONES, 1, 0, 0, 1, "subwb_chain");
    issue(0, MSB, ZERO, 0, 3'b101, MAXP, 0, 0, 1, 0, "dec_ovf");
    issue(0, MSB, ONES, 0, 3'b010, MSB, 0, 0, 0, 1, "mov");
    issue(0, 128'h3, 128'h5, 0, 3'b011, {ONES[DW-1:1], 1'b0}, 1, 0, 0, 1, "sub_neg");
    // Logic
    issue(0, 128'hF0F0, 128'h0FF0, 1, 3'b000, 128'h00F0, 0, 0, 0, 0, "and");
    issue(0, 128'hF0F0, 128'h0FF0, 1, 3'b001, 128'hFFF0, 0, 0, 0, 0, "or");
    issue(0, 128'hF0F0, 128'h0FF0, 1, 3'b010, 128'hFF00, 0, 0, 0, 0, "xor");
    issue(0, 128'hF0F0, 128'h0FF0, 1, 3'b011, NOTF0, 0, 0, 0, 1, "not");
    issue(0, 128'hF0F0, 128'h0FF0, 1, 3'b100, 128'h0FF0, 0, 0, 0, 0, "move");
    // Shift and reserved
    issue(0, MSB1, 128'h1, 1, 3'b101, 128'h2, 1, 0, 0, 0, "shl1");
    issue(0, MSB1, ZERO, 1, 3'b101, MSB1, 0, 0, 0, 1, "shl0");
    issue(0, TOP4, 128'h104, 1, 3'b101, 128'h10, 1, 0, 0, 0, "shl_hi_ignored");
    issue(0, ONES, ONES, 0, 3'b111, ZERO, 0, 1, 0, 0, "arith_reserved");
    issue(0, ONES, ONES, 1, 3'b111, ZERO, 0, 1, 0, 0, "logic_reserved");
`ifdef ALU_ROL_EN
    issue(0, MSB, 128'h1, 1, 3'b110, 128'h1, 1, 0, 0, 0, "rol1");
    issue(0, MSB1, ZERO, 1, 3'b110, MSB1, 0, 0, 0, 1, "rol0");
`else
    issue(0, MSB, 128'h1, 1, 3'b110, ZERO, 0, 1, 0, 0, "rol_reserved");
`endif
    // Reset mid-stream overrides an operation that would carry
    issue(1, ONES, ONES, 0, 3'b000, ZERO, 0, 0, 0, 0, "reset_mid");
    issue(0, ZERO, ZERO, 0, 3'b001, ZERO, 0, 1, 0, 0, "subwb_after_reset");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
